// File: rtl/RISCV_pkg.sv
// rtl/RISCV_pkg.sv - shared core types: datapath words, ALU control codes, EX/MEM entry
// Encodings of alu_ctrl_t follow the classic ALU-control decoder outputs.
package RISCV_pkg;

   localparam int XLEN_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_FULL  = 2'd1,
      BUF_SKID  = 2'd2
   } ex_buf_state_t;

   typedef struct packed {
      word_t                 alu_result;
      logic                  zero;
      word_t                 store_data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch_taken;
      word_t                 branch_target;
   } ex_mem_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - ID/EX -> EX/MEM handshake and payload bundle
// slave is the execute stage side, master is the upstream/downstream driver side.
interface ex_mem_stage_if;
   import RISCV_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   alu_ctrl_t             alu_ctrl;
   word_t                 operand_a;
   word_t                 operand_b;
   word_t                 store_data;
   word_t                 pc;
   word_t                 imm;
   logic [REG_ADDR_W-1:0] rd;
   logic                  reg_write;
   logic                  mem_read;
   logic                  mem_write;
   logic                  branch;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   ex_mem_t               out_bus;

   modport slave (
      input  in_valid, alu_ctrl, operand_a, operand_b, store_data, pc, imm, rd,
             reg_write, mem_read, mem_write, branch, flush, out_ready,
      output in_ready, out_valid, out_bus
   );

   modport master (
      output in_valid, alu_ctrl, operand_a, operand_b, store_data, pc, imm, rd,
             reg_write, mem_read, mem_write, branch, flush, out_ready,
      input  in_ready, out_valid, out_bus
   );

endinterface

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational execute-stage ALU
// Unknown control codes fall back to ADD so address generation never sees X.
module ex_alu
   import RISCV_pkg::*;
(
   input  alu_ctrl_t alu_ctrl,
   input  word_t     a,
   input  word_t     b,
   output word_t     result,
   output logic      zero
);

   always_comb begin
      result = a + b;
      case (alu_ctrl)
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         default: result = a + b;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage plus EX/MEM buffer with valid/ready and flush
// RISCV_EX_SKID_EN adds a skid entry so in_ready is registered and independent of out_ready.
module ex_mem_stage
   import RISCV_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RegAddrW = 5
)(
   input  logic           clk,
   input  logic           rst,
   ex_mem_stage_if.slave  bus
);

   if (XLEN != $bits(word_t) || RegAddrW != REG_ADDR_W) begin : g_bad_cfg
      $error("ex_mem_stage: XLEN/RegAddrW must match RISCV_pkg word_t/REG_ADDR_W");
   end

   localparam logic [1:0] ST_EMPTY = BUF_EMPTY;
   localparam logic [1:0] ST_FULL  = BUF_FULL;

   word_t   alu_result;
   logic    alu_zero;
   ex_mem_t in_entry;
   ex_mem_t main_q;
   logic [1:0] state;
   logic    accept;
   logic    drain;

   ex_alu u_alu (
      .alu_ctrl (bus.alu_ctrl),
      .a        (bus.operand_a),
      .b        (bus.operand_b),
      .result   (alu_result),
      .zero     (alu_zero)
   );

   always_comb begin
      in_entry               = '0;
      in_entry.alu_result    = alu_result;
      in_entry.zero          = alu_zero;
      in_entry.store_data    = bus.store_data;
      in_entry.rd            = bus.rd;
      in_entry.reg_write     = bus.reg_write;
      in_entry.mem_read      = bus.mem_read;
      in_entry.mem_write     = bus.mem_write;
      in_entry.branch_taken  = bus.branch & alu_zero;
      in_entry.branch_target = bus.pc + bus.imm;
   end

   assign accept        = bus.in_valid & bus.in_ready;
   assign drain         = bus.out_valid & bus.out_ready;
   assign bus.out_valid = (state != ST_EMPTY);
   assign bus.out_bus   = main_q;

`ifdef RISCV_EX_SKID_EN
   localparam logic [1:0] ST_SKID = BUF_SKID;

   ex_mem_t skid_q;
   logic    in_ready_q;

   assign bus.in_ready = in_ready_q;

   // in_ready_q tracks (state != SKID) for the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else if (bus.flush) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: if (accept) begin
               main_q <= in_entry;
               state  <= ST_FULL;
            end
            ST_FULL: begin
               if (accept && drain) begin
                  main_q <= in_entry;
               end else if (accept) begin
                  skid_q     <= in_entry;
                  state      <= ST_SKID;
                  in_ready_q <= 1'b0;
               end else if (drain) begin
                  state <= ST_EMPTY;
               end
            end
            ST_SKID: if (drain) begin
               main_q     <= skid_q;
               state      <= ST_FULL;
               in_ready_q <= 1'b1;
            end
            default: begin
               state      <= ST_EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end
`else
   assign bus.in_ready = !bus.out_valid | bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_EMPTY;
         main_q <= '0;
      end else if (bus.flush) begin
         state <= ST_EMPTY;
      end else if (accept) begin
         main_q <= in_entry;
         state  <= ST_FULL;
      end else if (drain) begin
         state <= ST_EMPTY;
      end
   end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage (both RISCV_EX_SKID_EN builds)
module tb_ex_mem_stage;
   import RISCV_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   ex_mem_t sb[$];

`ifdef RISCV_EX_SKID_EN
   localparam logic SKID = 1'b1;
`else
   localparam logic SKID = 1'b0;
`endif

   ex_mem_stage_if bus ();

   ex_mem_stage #(.XLEN(32), .RegAddrW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ex_mem_t model(input alu_ctrl_t c, input word_t a, input word_t b,
                                     input word_t sd, input logic [4:0] rd, input logic rw,
                                     input logic mr, input logic mw, input logic br,
                                     input word_t pcv, input word_t immv);
      ex_mem_t e;
      word_t   r;
      case (c)
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         default: r = a + b;
      endcase
      e.alu_result    = r;
      e.zero          = (r == 32'd0);
      e.store_data    = sd;
      e.rd            = rd;
      e.reg_write     = rw;
      e.mem_read      = mr;
      e.mem_write     = mw;
      e.branch_taken  = br && (r == 32'd0);
      e.branch_target = pcv + immv;
      return e;
   endfunction

   // Handshakes are resolved mid-cycle, when inputs and DUT outputs have settled.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) check("unexpected_out", bus.out_valid, 1'b0);
            else check("sb_out", bus.out_bus, sb.pop_front());
         end
         if (bus.flush) sb.delete();
         else if (bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.alu_ctrl, bus.operand_a, bus.operand_b, bus.store_data,
                               bus.rd, bus.reg_write, bus.mem_read, bus.mem_write,
                               bus.branch, bus.pc, bus.imm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input alu_ctrl_t c, input word_t a, input word_t b, input logic br,
                      input word_t pcv, input word_t immv);
      bus.alu_ctrl   = c;
      bus.operand_a  = a;
      bus.operand_b  = b;
      bus.store_data = a ^ 32'h5A5A_A5A5;
      bus.rd         = a[4:0];
      bus.reg_write  = !br;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.branch     = br;
      bus.pc         = pcv;
      bus.imm        = immv;
      bus.in_valid   = 1'b1;
   endtask

   initial begin
      int  idx;
      logic acc;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.flush = 1'b0;
      put(ALU_ADD, 0, 0, 1'b0, 0, 0);
      bus.in_valid = 1'b0;

      #1 rst = 1'b0;
      #2;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_bus", bus.out_bus, '0);
      tick();
      tick();
      rst = 1'b1;

      // SUB equal operands with branch: taken, target pc+imm
      bus.out_ready = 1'b1;
      put(ALU_SUB, 32'd5, 32'd5, 1'b1, 32'h100, 32'h20);
      tick();
      bus.in_valid = 1'b0;
      check("t1_valid", bus.out_valid, 1'b1);
      check("t1_result", bus.out_bus.alu_result, 32'd0);
      check("t1_zero", bus.out_bus.zero, 1'b1);
      check("t1_taken", bus.out_bus.branch_taken, 1'b1);
      check("t1_target", bus.out_bus.branch_target, 32'h120);
      tick();

      // ADD wraps to zero
      put(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h40, 32'h4);
      tick();
      bus.in_valid = 1'b0;
      check("t2_result", bus.out_bus.alu_result, 32'd0);
      check("t2_zero", bus.out_bus.zero, 1'b1);
      check("t2_taken", bus.out_bus.branch_taken, 1'b0);
      check("t2_memflags", {bus.out_bus.mem_read, bus.out_bus.mem_write}, 2'b00);
      tick();

      // three back-to-back ADDs under back-pressure
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         if (idx == 3 && !bus.out_valid) break;
         bus.out_ready = (c >= 3);
         if (idx < 3) put(ALU_ADD, 32'(idx + 1), 32'(idx + 1), 1'b0, 0, 0);
         else bus.in_valid = 1'b0;
         if (c == 0) check("t3_in_ready_c0", bus.in_ready, 1'b1);
         if (c == 1) check("t3_in_ready_c1", bus.in_ready, SKID);
         if (c == 2) check("t3_in_ready_c2", bus.in_ready, 1'b0);
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) idx++;
      end
      check("t3_all_sent", idx, 3);
      check("t3_drained", sb.size(), 0);

      // flush with buffer full (SKID in skid build) and a new input presented
      bus.out_ready = 1'b0;
      put(ALU_ADD, 32'd10, 32'd1, 1'b0, 0, 0);
      tick();
      put(ALU_ADD, 32'd20, 32'd2, 1'b0, 0, 0);
      tick();
      put(ALU_ADD, 32'd30, 32'd3, 1'b0, 0, 0);
      check("t4_in_ready_pre", bus.in_ready, 1'b0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check("t4_out_valid", bus.out_valid, 1'b0);
      check("t4_in_ready", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_no_ghost", bus.out_valid, 1'b0);
      end

      // asynchronous reset while FULL
      bus.out_ready = 1'b0;
      put(ALU_ADD, 32'd3, 32'd4, 1'b0, 32'h8, 32'h8);
      tick();
      bus.in_valid = 1'b0;
      check("t5_full", bus.out_valid, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_valid", bus.out_valid, 1'b0);
      check("t5_rst_bus", bus.out_bus, '0);
      sb.delete();
      tick();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      put(ALU_XOR, 32'hF0, 32'hFF, 1'b0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      check("t5_xor", bus.out_bus.alu_result, 32'h0F);
      tick();

      // undefined control code behaves as ADD
      put(alu_ctrl_t'(4'hF), 32'd3, 32'd4, 1'b0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      check("t6_undef", bus.out_bus.alu_result, 32'd7);
      tick();

      // random traffic against the scoreboard
      for (int i = 0; i < 60; i++) begin
         bus.alu_ctrl   = alu_ctrl_t'(4'($urandom_range(0, 15)));
         bus.operand_a  = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
         bus.operand_b  = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
         bus.store_data = $urandom;
         bus.rd         = 5'($urandom_range(0, 31));
         bus.reg_write  = 1'($urandom_range(0, 1));
         bus.mem_read   = 1'($urandom_range(0, 1));
         bus.mem_write  = 1'($urandom_range(0, 1));
         bus.branch     = 1'($urandom_range(0, 1));
         bus.pc         = $urandom;
         bus.imm        = $urandom;
         bus.in_valid   = 1'($urandom_range(0, 1));
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("rand_drained", sb.size(), 0);
      check("rand_empty", bus.out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage and EX/MEM pipeline register of the 5-stage RISC-V core. It consumes the ALU control code produced by the ALU control decoder together with the decoded operands, and computes the ALU result, zero flag and branch decision. Results are registered into an EX/MEM buffer with a valid/ready handshake, stall back-pressure and a flush input. The buffer output feeds the memory stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width; equals width of `word_t`.
- `RegAddrW`, 5: register-file address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  ID/EX presents a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `alu_ctrl`  in  `alu_ctrl_t`  operation code from the ALU control decoder.
- `operand_a`, `operand_b`  in  `word_t`  ALU operands, already forwarded and muxed.
- `store_data`  in  `word_t`  rs2 value for SW.
- `pc`, `imm`  in  `word_t`  instruction PC and sign-extended immediate.
- `rd`  in  `RegAddrW`  destination register.
- `reg_write`, `mem_read`, `mem_write`, `branch`  in  1 each  control bits from decode.
- `flush`  in  1  kill all buffered and incoming instructions.
- `out_valid`  out  1  EX/MEM entry valid.
- `out_ready`  in  1  memory stage accepts the entry.
- `out_bus`  out  `ex_mem_t`  fields `alu_result`, `zero`, `store_data`, `rd`, `reg_write`, `mem_read`, `mem_write`, `branch_taken`, `branch_target`.

## Operation
- ALU: ADD = a+b, SUB = a−b, AND, OR, XOR. Any other code gives the ADD result. All arithmetic is modulo 2^XLEN with no overflow flag.
- `zero` = (alu_result == 0). `branch_taken` = `branch` & `zero`. `branch_target` = `pc` + `imm`, modulo 2^XLEN.
- Transfer in occurs when `in_valid` & `in_ready`. Transfer out occurs when `out_valid` & `out_ready`.
- Buffer FSM has states EMPTY, FULL (main register valid) and SKID (main and skid registers valid):
  - EMPTY: on accept → FULL.
  - FULL:
    - accept without drain → SKID
    - drain without accept → EMPTY
    - accept and drain → FULL, holding new data
  - SKID: `in_ready`=0. On drain, the skid entry moves to main → FULL.
- Output order is strictly FIFO.
- `flush`: next state is EMPTY. An input presented in the same cycle is dropped. Flush has priority over any simultaneous accept or drain. Payload registers may retain stale data, but `out_valid` is 0.
- `out_bus` is stable while `out_valid` & !`out_ready`.

## Timing
- Latency: one cycle from accept to `out_valid`.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset (`rst`=0):
  - state EMPTY, `out_valid`=0
  - `out_bus` all zeros
  - `in_ready`=1 with the skid buffer, 1 without it
- Reset is honoured mid-transfer; the in-flight entry is lost.
- `in_valid` may not depend on `in_ready`. `in_valid` may deassert without handshake.

## Configuration
- `RISCV_EX_SKID_EN` defined:
  - skid register and SKID state present
  - `in_ready` is a registered signal, equal to (state != SKID)
  - no combinational path from `out_ready` to `in_ready`
- Undefined:
  - single register, states EMPTY/FULL only
  - `in_ready` = !`out_valid` | `out_ready`, combinational
  - same latency and throughput

## Structure
- `RISCV_pkg` gains the packed struct `ex_mem_t` and the buffer-state enum `ex_buf_state_t`. The existing `word_t`, `alu_ctrl_t` and its ADD/SUB/AND/OR/XOR members are reused.
- Sub-module `ex_alu`: combinational, (`alu_ctrl`, a, b) → (result, zero). The buffer and FSM stay in `ex_mem_stage`.

## Test plan
- SUB, a=5, b=5, branch=1, pc=0x100, imm=0x20, out_ready=1 → next cycle out_valid=1, alu_result=0, zero=1, branch_taken=1, branch_target=0x120.
- ADD, a=0xFFFFFFFF, b=1 → alu_result=0, zero=1, no other flag.
- Three back-to-back ADDs (1+1, 2+2, 3+3), out_ready held 0 for 2 cycles:
  - with skid: in_ready drops after the second accept
  - without skid: in_ready drops after the first accept
  - in both cases outputs are 2, 4, 6 in order once out_ready=1.
- SKID state with flush=1 and in_valid=1 in the same cycle → next cycle out_valid=0, state EMPTY, the incoming entry never appears.
- `rst` asserted while FULL → out_valid=0 immediately without waiting for a clock, out_bus=0. After release, the first accepted XOR 0xF0^0xFF gives 0x0F.
- Undefined alu_ctrl encoding with a=3, b=4 → alu_result=7.
